// File: rtl/debug_p2axi.sv
// Debug P-bus to AXI4-Lite master: issues one read or write per P-bus request.
// Optional hung-slave abort is compiled in with `define DEBUG_P2AXI_TIMEOUT_EN.
module debug_p2axi #(
    parameter logic [2:0]  AXI_PROT       = 3'b010,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        PVALID,
    output logic        PREADY,
    input  logic [3:0]  PWSTB,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PERR,
    output logic        ERR_STICKY,
    input  logic        ERR_CLR,

    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_AWADDR,
    output logic [2:0]  M_AWPROT,

    output logic        M_WVALID,
    input  logic        M_WREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,

    input  logic        M_BVALID,
    output logic        M_BREADY,
    input  logic [1:0]  M_BRESP,

    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    output logic [31:0] M_ARADDR,
    output logic [2:0]  M_ARPROT,

    input  logic        M_RVALID,
    output logic        M_RREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstb_q, wstb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] prdata_q, prdata_d;
    logic        perr_q, perr_d;
    logic        err_sticky_q, err_sticky_d;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_all;
    logic        w_all;

`ifdef DEBUG_P2AXI_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_hit;
`else
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Every output is a pure decode of registered state, so no AXI input
    // reaches an output combinationally.
    assign M_AWVALID  = (state_q == WADDR) && !aw_done_q;
    assign M_WVALID   = (state_q == WADDR) && !w_done_q;
    assign M_BREADY   = (state_q == WRESP);
    assign M_ARVALID  = (state_q == RADDR);
    assign M_RREADY   = (state_q == RDATA);
    assign PREADY     = (state_q == DONE);

    assign M_AWADDR   = addr_q;
    assign M_ARADDR   = addr_q;
    assign M_WDATA    = wdata_q;
    assign M_WSTRB    = wstb_q;
    assign M_AWPROT   = M_AWVALID ? AXI_PROT : 3'b000;
    assign M_ARPROT   = M_ARVALID ? AXI_PROT : 3'b000;

    assign PRDATA     = prdata_q;
    assign PERR       = perr_q;
    assign ERR_STICKY = err_sticky_q;

    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wstb_d       = wstb_q;
        wdata_d      = wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        prdata_d     = prdata_q;
        perr_d       = perr_q;
        err_sticky_d = err_sticky_q;

        aw_hs  = M_AWVALID && M_AWREADY;
        w_hs   = M_WVALID && M_WREADY;
        aw_all = aw_done_q || aw_hs;
        w_all  = w_done_q || w_hs;

        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (PVALID) begin
                    addr_d  = PADDR;
                    wstb_d  = PWSTB;
                    wdata_d = PWDATA;
                    state_d = (PWSTB != 4'h0) ? WADDR : RADDR;
                end
            end
            WADDR: begin
                aw_done_d = aw_all;
                w_done_d  = w_all;
                if (aw_all && w_all) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (M_BVALID) begin
                    prdata_d = 32'h0;
                    perr_d   = (M_BRESP != 2'b00);
                    state_d  = DONE;
                end
            end
            RADDR: begin
                if (M_ARREADY) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (M_RVALID) begin
                    prdata_d = M_RDATA;
                    perr_d   = (M_RRESP != 2'b00);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DEBUG_P2AXI_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = 16'h0;
        end else if (state_q != DONE) begin
            cnt_d       = cnt_q + 16'd1;
            timeout_hit = (cnt_q == TO_LAST);
        end
        // A completion landing on the same edge as the limit still wins.
        if (timeout_hit && (state_d != DONE)) begin
            state_d   = DONE;
            perr_d    = 1'b1;
            prdata_d  = 32'h0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
`endif

        // Set has priority over a clear arriving in the same cycle.
        if ((state_q == DONE) && perr_q) begin
            err_sticky_d = 1'b1;
        end else if (ERR_CLR) begin
            err_sticky_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values computed before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            wstb_q       <= 4'h0;
            wdata_q      <= 32'h0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            prdata_q     <= 32'h0;
            perr_q       <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wstb_q       <= wstb_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            prdata_q     <= prdata_d;
            perr_q       <= perr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef DEBUG_P2AXI_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= 16'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
